// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and default link constants.
// Used by the buffered transmitter (uart_tx_fifo) and the receiver.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_BAUD_RATE  = 19200;
    localparam int UART_CLK_FREQ   = 50000000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Bits on the wire per character: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_width, input bit parity_en);
        return data_width + 2 + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty from pointer compare.
// Push while full and pop while empty are ignored.
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_pop,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_wr_ptr - r_rd_ptr;

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Pointer update; pointers wrap naturally through the extra MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte input, FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int BAUD_RATE    = UART_BAUD_RATE,
    parameter int CLK_FREQ     = UART_CLK_FREQ,
    parameter int CLOCK_DIVIDE = CLK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLOCK_DIVIDE);
    localparam int IW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_full;
    logic                  w_empty;
    logic [AW:0]           w_count;
    logic                  w_pop;
    logic                  w_cell_done;
    logic                  w_last_bit;
    logic                  w_state_change;

    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic [CW-1:0]         r_baud;
    logic [IW-1:0]         r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_txd;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_cell_done    = (r_baud == CW'(CLOCK_DIVIDE - 1));
    assign w_last_bit     = (r_bit_idx == IW'(DATA_WIDTH - 1));
    assign w_state_change = (w_state_next != r_state);

    assign in_ready   = !w_full;
    assign txd        = r_txd;
    assign fifo_count = w_count;
    assign busy       = (r_state != IDLE) || (w_count != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and FIFO pop; STOP chains straight into START when data waits.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_cell_done) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_cell_done && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_cell_done) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_cell_done) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Baud counter: restarts at every cell boundary and every state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud <= '0;
        end else if (r_state == IDLE || w_cell_done || w_state_change) begin
            r_baud <= '0;
        end else begin
            r_baud <= r_baud + CW'(1);
        end
    end

    // Data bit index, counts cells while in DATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_idx <= '0;
        end else if (r_state != DATA) begin
            r_bit_idx <= '0;
        end else if (w_cell_done) begin
            r_bit_idx <= w_last_bit ? '0 : r_bit_idx + IW'(1);
        end
    end

    // Shift register: load on pop, shift right LSB-first after each data cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_pop) begin
            r_shift <= w_fifo_data;
        end else if (r_state == DATA && w_cell_done) begin
            r_shift <= r_shift >> 1;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity captured when the byte leaves the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_fifo_data;
        end
    end
`endif

    // Registered line driver, one cycle behind the state it reflects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txd <= 1'b1;
        end else begin
            case (r_state)
                START:   r_txd <= 1'b0;
                DATA:    r_txd <= r_shift[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  r_txd <= r_parity;
`endif
                default: r_txd <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (CLOCK_DIVIDE=16, FIFO_DEPTH=16).
// A line decoder and byte queue model check every frame on txd.
module tb_uart_tx_fifo;

    localparam int CD = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int LIMIT = 40 * CD;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       txd;
    logic       busy;
    logic [4:0] fifo_count;

    int     n_assert;
    int     n_fail;
    longint cyc;

    logic [7:0] got_q[$];
    logic       par_q[$];
    longint     fall_q[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo #(
        .DATA_WIDTH   (8),
        .BAUD_RATE    (1),
        .CLK_FREQ     (16),
        .CLOCK_DIVIDE (16),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input int max_wait,
                             output int waited);
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < max_wait) begin
            tick(1);
            waited++;
        end
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_accept: in_ready=%b after %0d cycles, required 1",
                     in_ready, waited);
        end
        tick(1);
        in_valid = 1'b0;
    endtask

    // Decodes n frames from txd, sampling each cell at its middle.
    task automatic collect(input int n);
        logic [7:0] b;
        logic       p;
        int         cnt;
        for (int f = 0; f < n; f++) begin
            cnt = 0;
            while (txd !== 1'b0 && cnt < LIMIT) begin
                tick(1);
                cnt++;
            end
            n_assert++;
            if (txd !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_start: frame %0d txd=%b, required 0", f, txd);
                return;
            end
            fall_q.push_back(cyc);
            tick(CD / 2);
            n_assert++;
            if (txd !== 1'b0) begin
                n_fail++;
                $display("FAIL start_bit: frame %0d txd=%b, required 0", f, txd);
            end
            for (int k = 0; k < 8; k++) begin
                tick(CD);
                b[k] = txd;
            end
`ifdef UART_TX_PARITY_EN
            tick(CD);
            p = txd;
            par_q.push_back(p);
            n_assert++;
            if (p !== ^b) begin
                n_fail++;
                $display("FAIL parity_bit: frame %0d got %b, required %b", f, p, ^b);
            end
`else
            p = 1'b0;
`endif
            tick(CD);
            n_assert++;
            if (txd !== 1'b1) begin
                n_fail++;
                $display("FAIL stop_bit: frame %0d txd=%b, required 1", f, txd);
            end
            got_q.push_back(b);
        end
    endtask

    task automatic compare_queues(input string name);
        n_assert++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d frames, required %0d",
                     name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_assert++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_byte%0d: got %h, required %h",
                         name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic clear_model();
        got_q.delete();
        par_q.delete();
        fall_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick(3);
        rst = 1'b0;
        tick(1);
        n_assert++;
        if (txd !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_txd: got %b, required 1", txd);
        end
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        n_assert++;
        if (fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d, required 0", fifo_count);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp;
        exp      = 8'hA5;
        in_data  = exp;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        n_assert++;
        if (fifo_count !== 5'd1 || busy !== 1'b1 || txd !== 1'b1) begin
            n_fail++;
            $display("FAIL single_push: count=%0d busy=%b txd=%b, required 1 1 1",
                     fifo_count, busy, txd);
        end
        tick(1);
        n_assert++;
        if (fifo_count !== 5'd0 || txd !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pop: count=%0d txd=%b, required 0 1",
                     fifo_count, txd);
        end
        tick(1);
        n_assert++;
        if (txd !== 1'b0) begin
            n_fail++;
            $display("FAIL single_fall: txd=%b, required 0", txd);
        end
        tick(CD / 2);
        n_assert++;
        if (txd !== 1'b0) begin
            n_fail++;
            $display("FAIL single_start: txd=%b, required 0", txd);
        end
        for (int k = 0; k < 8; k++) begin
            tick(CD);
            n_assert++;
            if (txd !== exp[k]) begin
                n_fail++;
                $display("FAIL single_bit%0d: txd=%b, required %b", k, txd, exp[k]);
            end
        end
`ifdef UART_TX_PARITY_EN
        tick(CD);
        n_assert++;
        if (txd !== 1'b0) begin
            n_fail++;
            $display("FAIL single_parity: txd=%b, required 0", txd);
        end
`endif
        tick(CD);
        n_assert++;
        if (txd !== 1'b1) begin
            n_fail++;
            $display("FAIL single_stop: txd=%b, required 1", txd);
        end
        tick(6);
        n_assert++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_hold: busy=%b, required 1", busy);
        end
        tick(1);
        n_assert++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_drop: busy=%b txd=%b, required 0 1", busy, txd);
        end
    endtask

    task automatic test_back_to_back();
        clear_model();
        fork
            begin
                int w;
                for (int i = 0; i < 18; i++) begin
                    push_byte(8'(i), 400, w);
                    exp_q.push_back(8'(i));
                    if (i == 16) begin
                        n_assert++;
                        if (fifo_count !== 5'd16 || in_ready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL b2b_full: count=%0d in_ready=%b, required 16 0",
                                     fifo_count, in_ready);
                        end
                    end
                    if (i == 17) begin
                        n_assert++;
                        if (w < CD * FB - 20 || w > CD * FB) begin
                            n_fail++;
                            $display("FAIL b2b_held: waited %0d cycles, required %0d..%0d",
                                     w, CD * FB - 20, CD * FB);
                        end
                    end
                end
            end
            begin
                collect(18);
            end
        join
        compare_queues("b2b");
    endtask

    task automatic test_gap();
        clear_model();
        fork
            begin
                int w;
                push_byte(8'h55, 10, w);
                exp_q.push_back(8'h55);
                push_byte(8'hFF, 10, w);
                exp_q.push_back(8'hFF);
            end
            begin
                collect(2);
            end
        join
        compare_queues("gap");
        n_assert++;
        if (fall_q.size() != 2 || fall_q[1] - fall_q[0] != longint'(CD * FB)) begin
            n_fail++;
            $display("FAIL gap_spacing: frame spacing %0d, required %0d",
                     fall_q.size() == 2 ? fall_q[1] - fall_q[0] : -1, CD * FB);
        end
        tick(CD);
    endtask

    task automatic test_random();
        clear_model();
        fork
            begin
                int w;
                logic [7:0] b;
                for (int i = 0; i < 24; i++) begin
                    b = 8'($urandom);
                    push_byte(b, 400, w);
                    exp_q.push_back(b);
                    tick($urandom_range(0, 3));
                end
            end
            begin
                collect(24);
            end
        join
        compare_queues("rand");
        tick(CD);
    endtask

    task automatic test_reset_mid();
        int w;
        int low_cycles;
        clear_model();
        push_byte(8'h3C, 10, w);
        push_byte(8'h11, 10, w);
        push_byte(8'h22, 10, w);
        push_byte(8'h33, 10, w);
        push_byte(8'h44, 10, w);
        n_assert++;
        if (fifo_count !== 5'd4) begin
            n_fail++;
            $display("FAIL mid_queued: count=%0d, required 4", fifo_count);
        end
        tick(36);
        n_assert++;
        if (txd !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_bit1: txd=%b, required 0", txd);
        end
        tick(32);
        n_assert++;
        if (txd !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_bit3: txd=%b busy=%b, required 1 1", txd, busy);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_assert++;
        if (txd !== 1'b1 || fifo_count !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: txd=%b count=%0d busy=%b ready=%b, required 1 0 0 1",
                     txd, fifo_count, busy, in_ready);
        end
        low_cycles = 0;
        for (int i = 0; i < 25 * CD; i++) begin
            tick(1);
            if (txd !== 1'b1) low_cycles++;
        end
        n_assert++;
        if (low_cycles != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_silent: %0d low cycles busy=%b, required 0 0",
                     low_cycles, busy);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        clear_model();
        fork
            begin
                int w;
                push_byte(8'h07, 10, w);
                exp_q.push_back(8'h07);
                tick(CD * FB);
                push_byte(8'h03, 10, w);
                exp_q.push_back(8'h03);
            end
            begin
                collect(2);
            end
        join
        compare_queues("par");
        n_assert++;
        if (par_q.size() != 2 || par_q[0] !== 1'b1 || par_q[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_values: got %0d bits, first two must be 1 0",
                     par_q.size());
        end
        tick(CD);
    endtask
`endif

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_single();
        tick(4);
        test_back_to_back();
        tick(4);
        test_gap();
        test_random();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
